// File: rtl/sq_wave_if.sv
// Control/status bundle between the timebase side and the square-wave stage.
// The master drives enable, tick and lengths; the slave returns wave and period_done.
interface sq_wave_if #(
  parameter int W = 4
);
  logic         en;
  logic         tick;
  logic [W-1:0] m;
  logic [W-1:0] n;
  logic         wave;
  logic         period_done;

  modport master (
    output en,
    output tick,
    output m,
    output n,
    input  wave,
    input  period_done
  );

  modport slave (
    input  en,
    input  tick,
    input  m,
    input  n,
    output wave,
    output period_done
  );
endinterface

// File: rtl/sq_wave_ctrl.sv
// Square-wave generator clocked by upstream timebase ticks: high for m ticks,
// low for n ticks, with a one-cycle period_done pulse at each period boundary.
module sq_wave_ctrl #(
  parameter int W = 4
) (
  input  logic      clk,
  input  logic      reset,
  sq_wave_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] m_reg;
  logic [W-1:0] n_reg;
  logic         wave_q;
  logic         pd_q;
  logic [W-1:0] len;
  logic         phase_end;

  function automatic state_t start_state(input logic [W-1:0] mm, input logic [W-1:0] nn);
    if (mm != '0) return HIGH;
    if (nn != '0) return LOW;
    return IDLE;
  endfunction

  // A phase length is never zero while in that phase, so len-1 cannot underflow.
  always_comb begin
    len       = (state == HIGH) ? m_reg : n_reg;
    phase_end = bus.tick && (cnt == len - W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      m_reg  <= '0;
      n_reg  <= '0;
      wave_q <= 1'b0;
      pd_q   <= 1'b0;
    end else begin
      pd_q <= 1'b0;
      if (!bus.en) begin
        state  <= IDLE;
        cnt    <= '0;
        wave_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            m_reg  <= bus.m;
            n_reg  <= bus.n;
            cnt    <= '0;
            state  <= start_state(bus.m, bus.n);
            wave_q <= (bus.m != '0);
          end
          HIGH, LOW: begin
            if (phase_end) begin
              cnt <= '0;
              if (state == HIGH && n_reg != '0) begin
                state  <= LOW;
                wave_q <= 1'b0;
              end else begin
                // Period boundary: pick up fresh lengths and restart.
                pd_q   <= 1'b1;
                m_reg  <= bus.m;
                n_reg  <= bus.n;
                state  <= start_state(bus.m, bus.n);
                wave_q <= (bus.m != '0);
              end
            end else if (bus.tick) begin
              cnt <= cnt + W'(1);
            end
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            wave_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.wave        = wave_q;
  assign bus.period_done = pd_q;

endmodule

// File: tb/tb_sq_wave_ctrl.sv
// Bench for sq_wave_ctrl: fixed vector table, directed period sequences and
// randomized traffic checked against a period-position reference model.
module tb_sq_wave_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sq_wave_if #(.W(4)) bus_if ();

  sq_wave_ctrl #(.W(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference: position within the period in ticks; wave is high while pos < M.
  int mp_pos, mp_m, mp_n;
  bit mp_act, exp_wave, exp_pd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mp_act = 0; mp_pos = 0; mp_m = 0; mp_n = 0; exp_wave = 0; exp_pd = 0;
    end else begin
      exp_pd = 0;
      if (!bus_if.en) begin
        mp_act = 0; mp_pos = 0;
      end else if (!mp_act) begin
        mp_m = int'(bus_if.m); mp_n = int'(bus_if.n); mp_pos = 0;
        mp_act = (mp_m + mp_n) > 0;
      end else if (bus_if.tick) begin
        mp_pos++;
        if (mp_pos == mp_m + mp_n) begin
          exp_pd = 1;
          mp_m = int'(bus_if.m); mp_n = int'(bus_if.n); mp_pos = 0;
          mp_act = (mp_m + mp_n) > 0;
        end
      end
      exp_wave = mp_act && (mp_pos < mp_m);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs at a falling edge, let one rising edge pass, compare to the model.
  task automatic step(input bit e, input bit t, input logic [3:0] mm, input logic [3:0] nn);
    bus_if.en = e; bus_if.tick = t; bus_if.m = mm; bus_if.n = nn;
    @(negedge clk);
    chk("model_wave", int'(bus_if.wave), int'(exp_wave));
    chk("model_pd", int'(bus_if.period_done), int'(exp_pd));
  endtask

  // Run from IDLE with a fixed tick divider; check period_done spacing in clk cycles.
  task automatic run_seq(input string name, input logic [3:0] mm, input logic [3:0] nn,
                         input int div, input int cycles, input int exp_int);
    int last = -1;
    int pds = 0;
    step(1'b0, 1'b0, mm, nn);
    for (int i = 0; i < cycles; i++) begin
      step(1'b1, (i % div) == 0, mm, nn);
      if (bus_if.period_done) begin
        pds++;
        if (last >= 0) chk({name, "_interval"}, i - last, exp_int);
        if (mm != 0) chk({name, "_pd_with_rise"}, int'(bus_if.wave), 1);
        last = i;
      end
    end
    if (exp_int == 0) chk({name, "_no_pulses"}, pds, 0);
    else chk({name, "_enough_pulses"}, int'(pds >= 3), 1);
  endtask

  typedef struct {
    bit         en;
    bit         tick;
    logic [3:0] m;
    logic [3:0] n;
    bit         w;
    bit         pd;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{0, 0, 4'd2, 4'd1, 0, 0};
    vt[1]  = '{1, 0, 4'd2, 4'd1, 1, 0};
    vt[2]  = '{1, 1, 4'd2, 4'd1, 1, 0};
    vt[3]  = '{1, 1, 4'd2, 4'd1, 0, 0};
    vt[4]  = '{1, 0, 4'd2, 4'd1, 0, 0};
    vt[5]  = '{1, 1, 4'd2, 4'd1, 1, 1};
    vt[6]  = '{1, 1, 4'd5, 4'd1, 1, 0};
    vt[7]  = '{0, 1, 4'd5, 4'd1, 0, 0};
    vt[8]  = '{1, 1, 4'd0, 4'd0, 0, 0};
    vt[9]  = '{1, 1, 4'd0, 4'd1, 0, 0};
    vt[10] = '{1, 1, 4'd0, 4'd1, 0, 1};
    vt[11] = '{1, 1, 4'd1, 4'd0, 1, 1};
    vt[12] = '{1, 1, 4'd1, 4'd0, 1, 1};
    vt[13] = '{1, 0, 4'd1, 4'd0, 1, 0};

    bus_if.en = 0; bus_if.tick = 0; bus_if.m = '0; bus_if.n = '0;
    repeat (2) @(negedge clk);
    chk("reset_wave", int'(bus_if.wave), 0);
    chk("reset_pd", int'(bus_if.period_done), 0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].en, vt[i].tick, vt[i].m, vt[i].n);
      chk($sformatf("vec%0d_wave", i), int'(bus_if.wave), int'(vt[i].w));
      chk($sformatf("vec%0d_pd", i), int'(bus_if.period_done), int'(vt[i].pd));
    end

    run_seq("basic_3_2", 4'd3, 4'd2, 10, 260, 50);
    run_seq("const_low", 4'd0, 4'd5, 1, 40, 5);
    run_seq("const_high", 4'd5, 4'd0, 1, 40, 5);
    run_seq("all_zero", 4'd0, 4'd0, 1, 30, 0);
    run_seq("max_len", 4'd15, 4'd15, 1, 130, 30);

    // Reprogram during HIGH: the running period keeps 3/2, the next one uses 1/4.
    step(1'b0, 1'b0, 4'd3, 4'd2);
    step(1'b1, 1'b0, 4'd3, 4'd2);
    step(1'b1, 1'b1, 4'd1, 4'd4);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 4'd1, 4'd4);

    // Enable drops on a tick mid-LOW, then a fresh full HIGH phase.
    step(1'b0, 1'b0, 4'd2, 4'd3);
    step(1'b1, 1'b0, 4'd2, 4'd3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd2, 4'd3);
    step(1'b0, 1'b1, 4'd2, 4'd3);
    chk("endrop_wave", int'(bus_if.wave), 0);
    chk("endrop_pd", int'(bus_if.period_done), 0);
    step(1'b1, 1'b0, 4'd2, 4'd3);
    chk("reen_wave", int'(bus_if.wave), 1);
    step(1'b1, 1'b1, 4'd2, 4'd3);
    step(1'b1, 1'b1, 4'd2, 4'd3);
    chk("reen_high_len", int'(bus_if.wave), 0);

    // Asynchronous reset between edges in the middle of HIGH.
    step(1'b0, 1'b0, 4'd3, 4'd2);
    step(1'b1, 1'b0, 4'd3, 4'd2);
    step(1'b1, 1'b1, 4'd3, 4'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wave", int'(bus_if.wave), 0);
    chk("async_rst_pd", int'(bus_if.period_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'd3, 4'd2);
    chk("post_rst_rise", int'(bus_if.wave), 1);

    // Randomized traffic against the reference model.
    begin
      logic [3:0] rm = 4'd2, rn = 4'd3;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(7) == 0) rm = 4'($urandom_range(15));
        if ($urandom_range(7) == 0) rn = 4'($urandom_range(15));
        step($urandom_range(19) != 0, $urandom_range(2) == 0, rm, rn);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
